// File: rtl/operand_fwd_ctrl_pkg.sv
// Shared constants for the ID-stage operand forwarding controller:
// forwarding select encodings and default widths.
package operand_fwd_ctrl_pkg;

    localparam int REGW_DEFAULT = 5;
    localparam int CNTW_DEFAULT = 32;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG  = 2'd0;
    localparam fwd_sel_t FWD_EALU = 2'd1;
    localparam fwd_sel_t FWD_MALU = 2'd2;
    localparam fwd_sel_t FWD_MMEM = 2'd3;

endpackage

// File: rtl/operand_fwd_ctrl_if.sv
// Decode-side bundle between the ID stage and the forwarding controller.
// The decoder is the master; the controller is the slave.
interface operand_fwd_ctrl_if #(
    parameter int REGW = 5,
    parameter int CNTW = 32
);
    logic [REGW-1:0] drs;
    logic [REGW-1:0] drt;
    logic            duse_rs;
    logic            duse_rt;
    logic [REGW-1:0] drn;
    logic            dwreg;
    logic            dm2reg;
    logic            daluimm;
    logic            dflush;

    logic [1:0]      fwda;
    logic [1:0]      fwdb;
    logic            stall;
    logic            ealuimm;
    logic            ewreg;
    logic            em2reg;
    logic [REGW-1:0] ern;
    logic            mwreg;
    logic            mm2reg;
    logic [REGW-1:0] mrn;
    logic            wwreg;
    logic [REGW-1:0] wrn;
    logic [CNTW-1:0] stall_count;

    modport master (
        output drs, drt, duse_rs, duse_rt, drn, dwreg, dm2reg, daluimm, dflush,
        input  fwda, fwdb, stall, ealuimm, ewreg, em2reg, ern,
               mwreg, mm2reg, mrn, wwreg, wrn, stall_count
    );

    modport slave (
        input  drs, drt, duse_rs, duse_rt, drn, dwreg, dm2reg, daluimm, dflush,
        output fwda, fwdb, stall, ealuimm, ewreg, em2reg, ern,
               mwreg, mm2reg, mrn, wwreg, wrn, stall_count
    );
endinterface

// File: rtl/operand_fwd_ctrl_fwd_sel.sv
// Combinational forwarding select for a single source operand,
// choosing the youngest in-flight producer in E or M.
module operand_fwd_ctrl_fwd_sel
    import operand_fwd_ctrl_pkg::*;
#(
    parameter int REGW = REGW_DEFAULT
) (
    input  logic [REGW-1:0] x_i,
    input  logic            use_i,
    input  logic            ewreg_i,
    input  logic            em2reg_i,
    input  logic [REGW-1:0] ern_i,
    input  logic            mwreg_i,
    input  logic            mm2reg_i,
    input  logic [REGW-1:0] mrn_i,
    output fwd_sel_t        sel_o
);

    // A load in E has no data yet, so it falls through to M; the stall covers it.
    always_comb begin
        sel_o = FWD_REG;
        if (use_i && (x_i != '0)) begin
            if (ewreg_i && (ern_i == x_i) && !em2reg_i) begin
                sel_o = FWD_EALU;
            end else if (mwreg_i && (mrn_i == x_i)) begin
                sel_o = mm2reg_i ? FWD_MMEM : FWD_MALU;
            end
        end
    end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// ID-stage operand forwarding controller: tracks E/M/W destination flags,
// produces qa/qb bypass selects, load-use stall and a saturating stall counter.
module operand_fwd_ctrl
    import operand_fwd_ctrl_pkg::*;
#(
    parameter int REGW = REGW_DEFAULT,
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    operand_fwd_ctrl_if.slave   bus
);

    logic            ewreg_q, ewreg_d;
    logic            em2reg_q, em2reg_d;
    logic            ealuimm_q, ealuimm_d;
    logic [REGW-1:0] ern_q, ern_d;
    logic            mwreg_q, mwreg_d;
    logic            mm2reg_q, mm2reg_d;
    logic [REGW-1:0] mrn_q, mrn_d;
    logic            wwreg_q, wwreg_d;
    logic [REGW-1:0] wrn_q, wrn_d;
    logic [CNTW-1:0] stall_count_q, stall_count_d;

    logic            load_use;
    logic            take_e;
    fwd_sel_t        sel_a;
    fwd_sel_t        sel_b;

    operand_fwd_ctrl_fwd_sel #(.REGW(REGW)) u_fwd_a (
        .x_i      (bus.drs),
        .use_i    (bus.duse_rs),
        .ewreg_i  (ewreg_q),
        .em2reg_i (em2reg_q),
        .ern_i    (ern_q),
        .mwreg_i  (mwreg_q),
        .mm2reg_i (mm2reg_q),
        .mrn_i    (mrn_q),
        .sel_o    (sel_a)
    );

    operand_fwd_ctrl_fwd_sel #(.REGW(REGW)) u_fwd_b (
        .x_i      (bus.drt),
        .use_i    (bus.duse_rt),
        .ewreg_i  (ewreg_q),
        .em2reg_i (em2reg_q),
        .ern_i    (ern_q),
        .mwreg_i  (mwreg_q),
        .mm2reg_i (mm2reg_q),
        .mrn_i    (mrn_q),
        .sel_o    (sel_b)
    );

    // A flushed instruction never stalls; it is replaced by a bubble instead.
    assign load_use = !bus.dflush && ewreg_q && em2reg_q && (ern_q != '0) &&
                      ((bus.duse_rs && (bus.drs == ern_q)) ||
                       (bus.duse_rt && (bus.drt == ern_q)));

    assign take_e = !load_use && !bus.dflush;

    always_comb begin
        ewreg_d   = take_e ? bus.dwreg   : 1'b0;
        em2reg_d  = take_e ? bus.dm2reg  : 1'b0;
        ealuimm_d = take_e ? bus.daluimm : 1'b0;
        ern_d     = take_e ? bus.drn     : '0;
        mwreg_d   = ewreg_q;
        mm2reg_d  = em2reg_q;
        mrn_d     = ern_q;
        wwreg_d   = mwreg_q;
        wrn_d     = mrn_q;
        stall_count_d = stall_count_q;
        if (load_use && (stall_count_q != {CNTW{1'b1}})) begin
            stall_count_d = stall_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ewreg_q       <= 1'b0;
            em2reg_q      <= 1'b0;
            ealuimm_q     <= 1'b0;
            ern_q         <= '0;
            mwreg_q       <= 1'b0;
            mm2reg_q      <= 1'b0;
            mrn_q         <= '0;
            wwreg_q       <= 1'b0;
            wrn_q         <= '0;
            stall_count_q <= '0;
        end else begin
            ewreg_q       <= ewreg_d;
            em2reg_q      <= em2reg_d;
            ealuimm_q     <= ealuimm_d;
            ern_q         <= ern_d;
            mwreg_q       <= mwreg_d;
            mm2reg_q      <= mm2reg_d;
            mrn_q         <= mrn_d;
            wwreg_q       <= wwreg_d;
            wrn_q         <= wrn_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.fwda        = sel_a;
    assign bus.fwdb        = sel_b;
    assign bus.stall       = load_use;
    assign bus.ealuimm     = ealuimm_q;
    assign bus.ewreg       = ewreg_q;
    assign bus.em2reg      = em2reg_q;
    assign bus.ern         = ern_q;
    assign bus.mwreg       = mwreg_q;
    assign bus.mm2reg      = mm2reg_q;
    assign bus.mrn         = mrn_q;
    assign bus.wwreg       = wwreg_q;
    assign bus.wrn         = wrn_q;
    assign bus.stall_count = stall_count_q;

endmodule
